// File: rtl/ff_bank_readout.sv
`default_nettype none
// ============================================================================
//  Module      : ff_bank_readout
//  Description : WIDTH-bit register bank with load enable, synchronous clear
//                value and power-up init value. A snapshot of the bank can be
//                shifted out LSB-first over a valid/ready serial link,
//                optionally followed by an even-parity beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module ff_bank_readout #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = WIDTH'(4'b0110),
    parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(4'b0000),
    parameter bit               PARITY   = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    input  logic             snap,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last
);

    // Beat counter must be able to hold WIDTH itself after the last data
    // beat, so it never wraps inside a frame.
    localparam int             c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    // Declaration initialisers give the FPGA power-up values.
    logic [WIDTH-1:0]   r_bank   = INIT_VAL;
    logic [WIDTH-1:0]   r_shadow = '0;
    logic               r_ptity  = 1'b0;
    logic [c_cnt_w-1:0] r_count  = '0;
    state_t             r_state  = ST_IDLE;

    state_t             w_state_next;
    logic               w_last_data;
    logic               w_xfer;

    assign q    = r_bank;
    assign busy = (r_state != ST_IDLE);

    assign w_last_data = (r_count == c_last_idx);
    assign w_xfer      = sout_valid && sout_ready;

    // Bank register: clear value wins, then parallel load; otherwise hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_bank <= RST_VAL;
        end else if (en) begin
            r_bank <= d;
        end
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shadow, parity and beat counter. The snapshot takes the pre-edge bank
    // value, so a load on the same edge does not leak into the frame.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_shadow <= '0;
            r_ptity  <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (snap) begin
                        r_shadow <= r_bank;
                        r_ptity  <= ^r_bank;
                        r_count  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_xfer) begin
                        r_shadow <= r_shadow >> 1;
                        r_count  <= r_count + c_cnt_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and serial outputs; outputs depend on state only, so they
    // stay stable while the sink stalls.
    always_comb begin
        w_state_next = r_state;
        sout_valid   = 1'b0;
        sout         = 1'b0;
        sout_last    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (snap) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sout_valid = 1'b1;
                sout       = r_shadow[0];
                sout_last  = w_last_data && !PARITY;
                if (sout_ready && w_last_data) begin
                    w_state_next = PARITY ? ST_PAR : ST_IDLE;
                end
            end
            ST_PAR: begin
                sout_valid = 1'b1;
                sout       = r_ptity;
                sout_last  = 1'b1;
                if (sout_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
